// File: rtl/bridge_pkg.sv
// Shared constants for the din/dout CPU bridge: register map, CTRL/STATUS bit
// positions and the request FSM state type.
package bridge_pkg;

    localparam logic [3:0] ADDR_DIN0   = 4'd0;
    localparam logic [3:0] ADDR_DIN3   = 4'd3;
    localparam logic [3:0] ADDR_DOUT0  = 4'd4;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;

    localparam int CTRL_REQ  = 0;
    localparam int CTRL_SEND = 1;
    localparam int CTRL_CLR  = 2;

    localparam int STAT_DIN_VALID = 0;
    localparam int STAT_BUSY      = 1;
    localparam int STAT_TIMEOUT   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/din_req_fsm.sv
// Request handshake FSM with wait-cycle timeout; emits one-cycle start,
// capture and timeout events for the register file in the bridge top.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no request outstanding, din_req low
// ST_WAIT | din_req high, waiting for din_rdy or the timeout count
module din_req_fsm
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic clk_sys,
    input  logic rst_b,
    input  logic req,
    input  logic clr,
    input  logic din_rdy,
    output logic busy,
    output logic start,
    output logic capture,
    output logic timeout
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

    fsm_state_t  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] cnt_inc;

    assign cnt_inc = cnt + 16'd1;
    assign busy    = (state == ST_WAIT);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture is tested before the timeout so a same-edge din_rdy wins.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        if (clr) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                        start     = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (din_rdy) begin
                        state_nxt = ST_IDLE;
                        capture   = 1'b1;
                    end else if (TO_EN && (cnt_inc == TO_LIMIT)) begin
                        state_nxt = ST_IDLE;
                        timeout   = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/din_dout_bridge.sv
// CPU-register bridge between a 32-bit request/ready data source and a strobed
// 32-bit sink. Define BRIDGE_IRQ_EN to add the capture/timeout irq output.
module din_dout_bridge
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  rdata,
    input  logic [31:0] din,
    input  logic        din_rdy,
    output logic        din_req,
    output logic [31:0] dout,
    output logic        dout_rdy
`ifdef BRIDGE_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        ctrl_wr, req, send, clr;
    logic        busy, start, capture, timeout;
    logic        din_valid, timeout_flag;
    logic [31:0] din_reg, dout_reg;
    logic [7:0]  status, rd_mux;

    assign ctrl_wr = wr && (addr == ADDR_CTRL);
    assign req     = ctrl_wr && wdata[CTRL_REQ];
    assign send    = ctrl_wr && wdata[CTRL_SEND];
    assign clr     = ctrl_wr && wdata[CTRL_CLR];

    din_req_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
        .clk_sys (clk),
        .rst_b   (rst),
        .req     (req),
        .clr     (clr),
        .din_rdy (din_rdy),
        .busy    (busy),
        .start   (start),
        .capture (capture),
        .timeout (timeout)
    );

    assign din_req = busy;
    assign dout    = dout_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_reg      <= '0;
            dout_reg     <= '0;
            din_valid    <= 1'b0;
            timeout_flag <= 1'b0;
            dout_rdy     <= 1'b0;
        end else begin
            dout_rdy <= send;
            if (capture) din_reg <= din;
            if (wr && (addr[3:2] == ADDR_DOUT0[3:2]))
                dout_reg[{addr[1:0], 3'b000} +: 8] <= wdata;
            // A capture and a byte3 read never coincide in practice; set wins.
            if (clr || start)                       din_valid <= 1'b0;
            else if (capture)                       din_valid <= 1'b1;
            else if (rd && (addr == ADDR_DIN3))     din_valid <= 1'b0;
            if (clr || start)                       timeout_flag <= 1'b0;
            else if (timeout)                       timeout_flag <= 1'b1;
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_DIN_VALID] = din_valid;
        status[STAT_BUSY]      = busy;
        status[STAT_TIMEOUT]   = timeout_flag;
    end

    always_comb begin
        rd_mux = '0;
        if (addr[3:2] == ADDR_DIN0[3:2])
            rd_mux = din_reg[{addr[1:0], 3'b000} +: 8];
        else if (addr[3:2] == ADDR_DOUT0[3:2])
            rd_mux = dout_reg[{addr[1:0], 3'b000} +: 8];
        else if (addr == ADDR_STATUS)
            rd_mux = status;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (rd) rdata <= rd_mux;
    end

`ifdef BRIDGE_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                irq <= 1'b0;
        else if (capture || timeout)             irq <= 1'b1;
        else if (clr || (rd && (addr == ADDR_STATUS))) irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_din_dout_bridge.sv
// Directed and randomized checks of din_dout_bridge against a cycle-count
// reference model of the request/capture/timeout rules.
module tb_din_dout_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  rdata;
    logic [31:0] din = '0;
    logic        din_rdy = 1'b0;
    logic        din_req;
    logic [31:0] dout;
    logic        dout_rdy;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] din_model;
    logic [31:0] rd32;
    logic [7:0]  rd8;
    int          hi_cnt;

    din_dout_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .wr       (wr),
        .rd       (rd),
        .rdata    (rdata),
        .din      (din),
        .din_rdy  (din_rdy),
        .din_req  (din_req),
        .dout     (dout),
        .dout_rdy (dout_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic read_din(output logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            cpu_read(4'(i), b);
            w[8*i +: 8] = b;
        end
    endtask

    // Count cycles din_req stays high after a REQ write; din_rdy is raised
    // at sample rdy_at (negative: never). Bounded by a cycle budget.
    task automatic count_req(input int rdy_at, output int cnt);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (!din_req) break;
            cnt++;
            if (c == rdy_at) din_rdy = 1'b1;
            tick();
        end
        din_rdy = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_din_req", 32'(din_req), 32'd0);
        check("rst_dout_rdy", 32'(dout_rdy), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b1;
        din_model = '0;
        tick();
        cpu_read(4'd9, rd8);
        check("rst_status", 32'(rd8), 32'h00);
        read_din(rd32);
        check("rst_din", rd32, 32'd0);

        // CLR together with REQ in IDLE: CLR wins
        cpu_write(4'd8, 8'h05);
        check("clr_req_din_req", 32'(din_req), 32'd0);
        cpu_read(4'd9, rd8);
        check("clr_req_status", 32'(rd8), 32'h00);

        // basic capture, din_rdy raised after the write
        din = 32'hBF820002;
        cpu_write(4'd8, 8'h01);
        check("req_din_req_hi", 32'(din_req), 32'd1);
        din_rdy = 1'b1;
        tick();
        check("cap_din_req_lo", 32'(din_req), 32'd0);
        din = 32'hDEADBEEF;
        din_model = 32'hBF820002;
        for (int i = 0; i < 3; i++) begin
            cpu_read(4'(i), rd8);
            check("din_byte", 32'(rd8), 32'(din_model[8*i +: 8]));
        end
        cpu_read(4'd9, rd8);
        check("status_valid", 32'(rd8), 32'h01);
        cpu_read(4'd3, rd8);
        check("din_byte3", 32'(rd8), 32'hBF);
        cpu_read(4'd9, rd8);
        check("status_after_b3", 32'(rd8), 32'h00);
        repeat (3) tick();
        check("rdata_hold", 32'(rdata), 32'h00);
        din_rdy = 1'b0;

        // din_rdy high during the REQ write is not captured that edge
        din = 32'h12345678;
        din_rdy = 1'b1;
        cpu_write(4'd8, 8'h01);
        check("same_cyc_din_req", 32'(din_req), 32'd1);
        tick();
        din_rdy = 1'b0;
        check("same_cyc_captured", 32'(din_req), 32'd0);
        din_model = 32'h12345678;
        cpu_read(4'd9, rd8);
        check("same_cyc_status", 32'(rd8), 32'h01);

        // timeout: din_req high TO cycles, DIN unchanged
        din = 32'hCAFEF00D;
        cpu_write(4'd8, 8'h01);
        count_req(-1, hi_cnt);
        check("to_req_cycles", 32'(hi_cnt), 32'(TO));
        cpu_read(4'd9, rd8);
        check("to_status", 32'(rd8), 32'h04);
        read_din(rd32);
        check("to_din_kept", rd32, din_model);

        // REQ rewritten in WAIT is ignored (timeout still from first write)
        cpu_write(4'd8, 8'h01);
        tick(); tick();
        cpu_write(4'd8, 8'h01);
        count_req(-1, hi_cnt);
        check("req_in_wait", 32'(hi_cnt), 32'(TO - 3));

        // DOUT and SEND
        cpu_write(4'd4, 8'h11);
        cpu_write(4'd5, 8'h22);
        cpu_write(4'd6, 8'h33);
        cpu_write(4'd7, 8'h44);
        check("dout_pre_send", dout, 32'h44332211);
        check("no_strobe_yet", 32'(dout_rdy), 32'd0);
        cpu_read(4'd6, rd8);
        check("dout_readback", 32'(rd8), 32'h33);
        cpu_write(4'd8, 8'h02);
        check("send_strobe", 32'(dout_rdy), 32'd1);
        check("send_dout", dout, 32'h44332211);
        tick();
        check("send_one_cycle", 32'(dout_rdy), 32'd0);

        // REQ+SEND together, then CLR during WAIT
        cpu_write(4'd8, 8'h03);
        check("req_send_strobe", 32'(dout_rdy), 32'd1);
        check("req_send_req", 32'(din_req), 32'd1);
        tick();
        cpu_write(4'd8, 8'h04);
        check("clr_wait_req", 32'(din_req), 32'd0);
        cpu_read(4'd9, rd8);
        check("clr_wait_status", 32'(rd8), 32'h00);

        // async reset during WAIT
        cpu_write(4'd8, 8'h01);
        check("pre_rst_req", 32'(din_req), 32'd1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_req", 32'(din_req), 32'd0);
        check("async_rst_dout", dout, 32'd0);
        tick();
        rst = 1'b1;
        din_model = '0;
        tick();
        cpu_read(4'd9, rd8);
        check("post_rst_status", 32'(rd8), 32'h00);
        read_din(rd32);
        check("post_rst_din", rd32, 32'd0);

        // randomized requests against the cycle-count model
        for (int it = 0; it < 12; it++) begin
            int          k;
            logic [31:0] nv;
            bit          got;
            k = int'($urandom_range(0, 11));
            nv = $urandom;
            din = nv;
            cpu_write(4'd8, 8'h01);
            count_req(k, hi_cnt);
            got = (k + 1 <= TO);
            check("rnd_req_cycles", 32'(hi_cnt), got ? 32'(k + 1) : 32'(TO));
            if (got) din_model = nv;
            din = $urandom;
            cpu_read(4'd9, rd8);
            check("rnd_status", 32'(rd8), got ? 32'h01 : 32'h04);
            read_din(rd32);
            check("rnd_din", rd32, din_model);
            cpu_read(4'd9, rd8);
            check("rnd_status_b3", 32'(rd8), got ? 32'h00 : 32'h04);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/din_dout_bridge.md
DIN_DOUT_BRIDGE -- requirements
Module: din_dout_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: WAIT-state timeout in clk cycles; 0 disables the timeout.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port addr, input, 4, CPU register address.
REQ-005 The block SHALL have port wdata, input, 8, CPU write data.
REQ-006 The block SHALL have port wr, input, 1, CPU write strobe, one cycle per access.
REQ-007 The block SHALL have port rd, input, 1, CPU read strobe, one cycle per access.
REQ-008 The block SHALL have port rdata, output, 8, registered CPU read data.
REQ-009 The block SHALL have port din, input, 32, external data word.
REQ-010 The block SHALL have port din_rdy, input, 1, external data-valid level.
REQ-011 The block SHALL have port din_req, output, 1, data request to the external source.
REQ-012 The block SHALL have port dout, output, 32, result word to the external sink.
REQ-013 The block SHALL have port dout_rdy, output, 1, one-cycle result strobe.

Function
REQ-014 Register map SHALL be: 0-3 DIN byte0..3 (RO, byte0 = din[7:0]); 4-7 DOUT byte0..3 (RW); 8 CTRL (WO: bit0 REQ, bit1 SEND, bit2 CLR); 9 STATUS (RO: bit0 DIN_VALID, bit1 BUSY, bit2 TIMEOUT); other addresses read 0x00 and ignore writes.
REQ-015 rdata SHALL present the addressed register one cycle after rd and hold it until the next rd.
REQ-016 FSM SHALL have states IDLE and WAIT; BUSY = (state == WAIT).
REQ-017 IDLE->WAIT on a CTRL write with REQ=1; this write clears DIN_VALID and TIMEOUT; din_req SHALL be high the cycle after the write and stay high throughout WAIT.
REQ-018 In WAIT, the first edge with din_rdy=1 SHALL capture din into DIN, set DIN_VALID, go to IDLE and drop din_req the next cycle; din_rdy is a level, and staying high afterwards SHALL cause no further capture.
REQ-019 din_rdy high in the cycle the REQ write occurs SHALL NOT be captured; capture needs din_req already high.
REQ-020 A 16-bit wait counter SHALL clear on WAIT entry and increment each WAIT cycle; on reaching TIMEOUT_CYCLES (nonzero) the block SHALL set TIMEOUT, go to IDLE, drop din_req and leave DIN unchanged.
REQ-021 A din_rdy capture on the same edge as timeout SHALL win: data captured, TIMEOUT stays 0.
REQ-022 A REQ write while in WAIT SHALL be ignored.
REQ-023 A CPU read of DIN byte3 SHALL clear DIN_VALID.
REQ-024 A CTRL write with SEND=1 SHALL drive dout_rdy high for exactly the next cycle; dout always equals {DOUT3..DOUT0} and is stable during that strobe.
REQ-025 REQ and SEND set in one write SHALL both take effect.
REQ-026 CLR SHALL force IDLE, drop din_req, and clear DIN_VALID and TIMEOUT; when set with REQ, CLR SHALL win.

Reset
REQ-027 While rst=0: state IDLE, din_req=0, dout_rdy=0, dout=0, rdata=0, DIN=0, DOUT=0, all STATUS bits 0, counter 0; rst low during WAIT SHALL abort the request immediately.

Configuration
REQ-028 With BRIDGE_IRQ_EN defined, the block SHALL add output irq (1 bit, reset 0), set on capture or timeout and cleared by a STATUS read or CLR; without the macro, irq SHALL not exist and function is otherwise unchanged.

Structure
REQ-029 Package bridge_pkg SHALL hold the register address constants, CTRL/STATUS bit indices and the FSM state type.
REQ-030 The FSM and wait counter SHALL live in sub-module din_req_fsm; the register file and read mux stay in the top.

Verification
REQ-031 Write CTRL=0x01, din_rdy held 1 with din=32'hBF820002 -> din_req high one cycle after the write, low after capture; DIN bytes read 02,00,82,BF; DIN_VALID clears after the byte3 read.
REQ-032 TIMEOUT_CYCLES=8, REQ, din_rdy=0 -> din_req high 8 cycles; STATUS=0x04; DIN unchanged.
REQ-033 Write DOUT=0x11,0x22,0x33,0x44 then CTRL=0x02 -> one-cycle dout_rdy with dout=32'h44332211.
REQ-034 din_rdy=1 in the same cycle as the CTRL=0x01 write -> no capture that cycle; capture on the next edge.
REQ-035 rst low during WAIT -> din_req=0 asynchronously; STATUS=0x00 after release.
REQ-036 CTRL=0x05 while in IDLE -> remains IDLE with din_req=0.
